// File: rtl/stream_arb_pkg.sv
// rtl/stream_arb_pkg.sv - shared types and round-robin pick helper for the stream arbiter
package stream_arb_pkg;

  localparam int MAX_N = 16;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;

  // Returns {found, idx}: first set bit of req scanning upward from last_grant+1 with wrap at n.
  function automatic logic [4:0] rr_pick(input logic [15:0] req, input logic [3:0] last_grant,
                                         input int unsigned n);
    logic [4:0]  res;
    int unsigned idx;
    res = '0;
    for (int unsigned k = 1; k <= MAX_N; k++) begin
      idx = (32'(last_grant) + k) % n;
      if (k <= n && !res[4] && req[idx[3:0]]) res = {1'b1, idx[3:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/stream_rr_arbiter_picker.sv
// rtl/stream_rr_arbiter_picker.sv - combinational rotate and priority encode for the idle grant
module rr_priority_picker
  import stream_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] last_grant,
  output logic [IDXW-1:0] grant,
  output logic            found
);

  logic [4:0] pick;

  assign pick  = rr_pick(16'(req), 4'(last_grant), N);
  assign found = pick[4];
  assign grant = IDXW'(pick[3:0]);

endmodule

// File: rtl/stream_rr_arbiter.sv
// rtl/stream_rr_arbiter.sv - round-robin packet-locking arbiter feeding one registered valid/ready stage
module stream_rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int WIDTH = 32,
  localparam int IDXW = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       in_valid,
  input  logic [N-1:0]       in_last,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_last,
  output logic [IDXW-1:0]    out_src,
  input  logic               out_ready
);

  arb_state_e        state;
  logic [IDXW-1:0]   lock_idx;
  logic [IDXW-1:0]   last_grant;
  logic [IDXW-1:0]   pick_idx;
  logic              pick_found;
  logic [IDXW-1:0]   grant;
  logic              stage_free;
  logic              grant_en;
  logic              accept;
  logic              sel_valid;
  logic              sel_last;
  logic [WIDTH-1:0]  sel_data;

  rr_priority_picker #(.N(N)) u_picker (
    .req        (in_valid),
    .last_grant (last_grant),
    .grant      (pick_idx),
    .found      (pick_found)
  );

  assign stage_free = !out_valid || out_ready;
  assign grant      = (state == ARB_LOCKED) ? lock_idx : pick_idx;
  // While locked the grant stays offered even if the owner bubbles, so nobody else slips in.
  assign grant_en   = rst_n && stage_free && (state == ARB_LOCKED || pick_found);
  assign accept     = sel_valid && grant_en;

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    in_ready  = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == IDXW'(i)) begin
        sel_valid   = in_valid[i];
        sel_last    = in_last[i];
        sel_data    = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = grant_en;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      lock_idx   <= '0;
      last_grant <= IDXW'(N - 1);
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      out_src    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_last  <= sel_last;
      out_src   <= grant;
      if (sel_last) begin
        state      <= ARB_IDLE;
        last_grant <= grant;
      end else begin
        state    <= ARB_LOCKED;
        lock_idx <= grant;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb/tb_stream_rr_arbiter.sv - scoreboard bench for stream_rr_arbiter with directed packet vectors
module tb_stream_rr_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  typedef struct packed {logic last; logic [W-1:0] data;} beat_t;
  typedef struct packed {logic [1:0] src; logic last; logic [W-1:0] data;} exp_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_last;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic [1:0]     out_src;
  logic           out_ready;

  beat_t    src_q[N][$];
  exp_t     exp_q[$];
  logic [N-1:0] hold;
  int       checks = 0;
  int       errors = 0;

  stream_rr_arbiter #(.N(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0 && !hold[i]) begin
        in_valid[i]      = 1'b1;
        in_last[i]       = src_q[i][0].last;
        in_data[i*W +: W] = src_q[i][0].data;
      end else begin
        in_valid[i]      = 1'b0;
        in_last[i]       = 1'b0;
        in_data[i*W +: W] = '0;
      end
    end
  endtask

  task automatic pop_accepted();
    for (int i = 0; i < N; i++)
      if (in_valid[i] && in_ready[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
  endtask

  task automatic send(input int r, input logic last, input logic [W-1:0] data);
    src_q[r].push_back({last, data});
  endtask

  task automatic expect_beat(input int r, input logic last, input logic [W-1:0] data);
    exp_q.push_back({2'(r), last, data});
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  // Upstream model: retire handshaken beats at the edge, present the next head shortly after.
  initial begin
    forever begin
      @(posedge clk);
      pop_accepted();
      #1;
      drive_inputs();
    end
  end

  // Scoreboard monitor: every output handshake must match the head of the expected queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {30'd0, out_src, out_last, out_data}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("out_beat", {30'd0, out_src, out_last, out_data}, {30'd0, e});
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b1;
    hold      = '0;
    in_valid  = '0;
    in_last   = '0;
    in_data   = '0;

    for (int i = 0; i < N; i++) begin
      send(i, 1'b1, 32'h1000_0000 + 32'(i));
      expect_beat(i, 1'b1, 32'h1000_0000 + 32'(i));
    end
    send(0, 1'b1, 32'h2000_0000);
    send(1, 1'b1, 32'h2000_0001);
    expect_beat(0, 1'b1, 32'h2000_0000);
    expect_beat(1, 1'b1, 32'h2000_0001);

    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("rr_no_bubble", 64'(out_valid), 64'd1);
    end
    wait_drain();

    // Packet lock: req1 locks before req2 shows up.
    send(1, 1'b0, 32'hA1);
    send(1, 1'b0, 32'hA2);
    send(1, 1'b1, 32'hA3);
    expect_beat(1, 1'b0, 32'hA1);
    expect_beat(1, 1'b0, 32'hA2);
    expect_beat(1, 1'b1, 32'hA3);
    expect_beat(2, 1'b1, 32'hB1);
    @(negedge clk);
    @(negedge clk);
    send(2, 1'b1, 32'hB1);
    @(negedge clk);
    chk("lock_ready2", 64'(in_ready[2]), 64'd0);
    chk("lock_ready1", 64'(in_ready[1]), 64'd1);
    @(negedge clk);
    chk("unlock_ready2", 64'(in_ready[2]), 64'd1);
    wait_drain();

    // Mid-packet bubble from req0 while req3 waits.
    send(0, 1'b0, 32'hC1);
    send(0, 1'b1, 32'hC2);
    expect_beat(0, 1'b0, 32'hC1);
    expect_beat(0, 1'b1, 32'hC2);
    expect_beat(3, 1'b1, 32'hD1);
    @(negedge clk);
    hold[0] = 1'b1;
    @(negedge clk);
    send(3, 1'b1, 32'hD1);
    @(negedge clk);
    chk("bubble_out_valid_a", 64'(out_valid), 64'd0);
    chk("bubble_ready3_a", 64'(in_ready[3]), 64'd0);
    chk("bubble_ready0", 64'(in_ready[0]), 64'd1);
    @(negedge clk);
    chk("bubble_out_valid_b", 64'(out_valid), 64'd0);
    chk("bubble_ready3_b", 64'(in_ready[3]), 64'd0);
    hold[0] = 1'b0;
    wait_drain();

    // Backpressure: output beat must hold still and no requester is accepted.
    out_ready = 1'b0;
    send(2, 1'b1, 32'hABCD_1234);
    send(2, 1'b1, 32'h0000_00E2);
    expect_beat(2, 1'b1, 32'hABCD_1234);
    expect_beat(2, 1'b1, 32'h0000_00E2);
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("bp_beat", {30'd0, out_src, out_last, out_data}, {30'd0, 2'd2, 1'b1, 32'hABCD_1234});
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_drain();

    // Reset mid-packet: req2's packet is abandoned, req3 goes straight through.
    send(2, 1'b0, 32'hF1);
    send(2, 1'b0, 32'hF2);
    send(2, 1'b1, 32'hF3);
    expect_beat(2, 1'b0, 32'hF1);
    expect_beat(3, 1'b1, 32'h0000_0061);
    @(negedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    src_q[2].delete();
    send(3, 1'b1, 32'h0000_0061);
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_grant3", {62'd0, out_src}, 64'd3);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_rr_arbiter.md
Name: stream_rr_arbiter

Overview:
- Shares one registered valid/ready output stage among N upstream requester streams.
- Uses round-robin arbitration with packet locking: once a requester's first beat is accepted, it holds the grant until its beat with last=1 is accepted.
- The output stage behaves as a single-entry pipeline register, one cycle in to out.
- Sits in front of the shared pipeline datapath and feeds it from several producers.

Parameters:
- N, 4, number of requesters (2..16).
- WIDTH, 32, data width per beat.
- IDXW, $clog2(N), localparam, width of the source index.

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  N  per-requester beat valid.
- in_last  input  N  per-requester end-of-packet flag, qualified by in_valid.
- in_data  input  N*WIDTH  per-requester data; requester i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  N  per-requester accept; at most one bit high per cycle.
- out_valid  output  1  registered output beat valid.
- out_data  output  WIDTH  registered output data.
- out_last  output  1  registered end-of-packet flag.
- out_src  output  IDXW  index of the requester that produced the current output beat.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset, while rst_n=0 at a rising edge:
  - out_valid=0, out_last=0, out_data=0, out_src=0.
  - state=IDLE, last_grant=N-1, so requester 0 wins first.
- in_ready is combinational and is 0 for all requesters during reset.
- stage_free = !out_valid || out_ready.
- States:
  - IDLE: grant = first i with in_valid[i]=1, scanning (last_grant+1) mod N upward with wrap.
  - LOCKED: grant = lock_idx, ignoring other requesters' valid.
- in_ready[grant] = stage_free && (state==LOCKED || any in_valid). All other in_ready bits are 0.
  - In LOCKED, in_ready[lock_idx] may be 1 while that requester's in_valid=0 (bubble mid-packet). The grant is held and no other requester is served.
- accept = in_valid[grant] && in_ready[grant].
- On accept: out_data, out_last and out_src load from the granted requester; out_valid=1.
- Else if out_ready: out_valid=0. The data, last and src registers hold.
- out_* must be stable while out_valid && !out_ready.
- Transitions:
  - IDLE -> LOCKED on accept with last=0; lock_idx=grant.
  - LOCKED -> IDLE on accept with last=1.
  - IDLE stays IDLE on accept with last=1 (single-beat packet).
- last_grant updates to the grant index on every accept with last=1 (packet end). It is never updated mid-packet.
- Latency: an accepted beat is visible on out_* the next cycle.
- Throughput is 1 beat/cycle with out_ready held high, including back-to-back packets from different requesters (no idle cycle at a packet switch).
- Simultaneous events:
  - out_ready=1 and accept in the same cycle: the output register is overwritten with the new beat and out_valid stays 1.
  - A new request arriving while LOCKED is not granted until the lock releases.
- Fairness: with all N requesting single-beat packets continuously, the grant order is 0,1,...,N-1,0,... and no requester waits more than N-1 packets.
- Reset mid-packet: lock is dropped, the output beat is discarded, and last_grant returns to N-1. Upstream must restart its packet.
- Requester data must be held while in_valid && !in_ready (standard valid/ready rule, not checked in RTL).

Decomposition:
- Package stream_arb_pkg:
  - typedef enum {ARB_IDLE, ARB_LOCKED} arb_state_e.
  - function rr_pick(req, last_grant), returning the next index plus a found flag.
- Sub-module rr_priority_picker (combinational rotate + priority encode, parameter N), instantiated once for IDLE grant selection.
- The output register lives inline in the top module.

Test Plan:
- Reset: hold rst_n=0 for 5 cycles with in_valid=4'b1111 -> in_ready=0 and out_valid=0 throughout. After release, the first accepted beat has out_src=0.
- Round-robin, single beats: all 4 requesters with last=1, data=32'h1000_0000+i, out_ready=1 -> out_src sequence 0,1,2,3,0,1 on consecutive cycles, out_data matches the source, no bubbles.
- Packet lock: req1 sends a 3-beat packet (32'hA1,A2,A3; last on A3) while req2 holds valid -> out_src=1 for 3 consecutive beats, then out_src=2. in_ready[2]=0 until A3 is accepted.
- Mid-packet bubble: req0 drops in_valid for 2 cycles between beats while req3 is valid -> out_valid=0 for 2 cycles, req3 is not granted, and req0's last beat follows, then req3.
- Backpressure: out_ready=0 for 4 cycles with out_data=32'hABCD_1234 -> out_* stable and all in_ready=0. After out_ready=1, the beat is consumed and the next beat follows the cycle after.
- Reset mid-packet: assert rst_n=0 after beat 1 of a 3-beat req2 packet -> out_valid=0 and state IDLE. A new req3 single beat is granted without waiting for req2's last.
